axis_frame_tx: RTL and testbench

AXIS_FRAME_TX -- requirements
Module: axis_frame_tx

---
 rtl/axis_pkg.sv | 18 +
 rtl/axis_skid.sv | 62 ++++++
 rtl/axis_frame_tx.sv | 120 ++++++++++++
 tb/tb_axis_frame_tx.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared stream definitions for the axis_* blocks: frame FSM states, default
// data width and the beat layout (data, user, last).
package axis_pkg;

    localparam int AXIS_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   user;
        logic                   last;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer for a valid/ready stream. The output register and
// s_ready are both registered, so nothing combinational runs from m_ready to s_ready.
module axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_v;
    logic             skid_v;
    logic             ready_q;
    logic             load_out;
    logic             push;

    // The output register may take new data when it is empty or being drained.
    assign load_out = !out_v || m_ready;
    assign push     = s_valid && ready_q;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: both data entries are reset as well, because the stream outputs must read 0 during reset.
        if (!reset) begin
            out_q   <= '0;
            skid_q  <= '0;
            out_v   <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            if (load_out) begin
                if (skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end else begin
                    out_v <= push;
                    if (push) begin
                        out_q <= s_data;
                    end
                end
            end else if (push) begin
                skid_q <= s_data;
                skid_v <= 1'b1;
            end
            // Ready next cycle exactly when the skid entry will be empty.
            ready_q <= load_out || (!skid_v && !push);
        end
    end

    assign s_ready = ready_q;
    assign m_valid = out_v;
    assign m_data  = out_q;

endmodule

// File: rtl/axis_frame_tx.sv
// Frames a pixel source onto an AXI4-Stream master (tuser = SOF, tlast = EOL).
// Define AXIS_FRAME_TX_LEN_CHECK_EN to build the sticky line-length checker.
module axis_frame_tx
    import axis_pkg::*;
#(
    parameter int DATA_W      = AXIS_DATA_W,
    parameter int LINE_WORDS  = 640,
    parameter int FRAME_LINES = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              frame_done,
    output logic              line_len_err,
    output logic              sof_miss
);

    localparam int WC_W = (LINE_WORDS  > 1) ? $clog2(LINE_WORDS)  : 1;
    localparam int LC_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(LINE_WORDS - 1);
    localparam logic [LC_W-1:0] LAST_LINE = LC_W'(FRAME_LINES - 1);

    // eof travels with the beat so frame_done fires on the master-side transfer.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              user;
        logic              last;
        logic              eof;
    } tx_beat_t;

    frame_state_t    state;
    logic [WC_W-1:0] word_cnt;
    logic [WC_W-1:0] cur_word;
    logic [LC_W-1:0] line_cnt;
    logic [LC_W-1:0] cur_line;
    logic            accept;
    logic            forward;
    logic            last_line;
    tx_beat_t        push_beat;
    tx_beat_t        out_beat;

    assign accept  = in_valid && in_ready;
    assign forward = accept && ((state == ACTIVE) || in_sof);

    // A sof beat in IDLE starts from cleared counters, so view IDLE as position 0.
    assign cur_word  = (state == ACTIVE) ? word_cnt : '0;
    assign cur_line  = (state == ACTIVE) ? line_cnt : '0;
    assign last_line = (cur_line == LAST_LINE);

    assign push_beat.data = in_data;
    assign push_beat.user = (state == IDLE);
    assign push_beat.last = in_eol;
    assign push_beat.eof  = in_eol && last_line;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            line_cnt <= '0;
            sof_miss <= 1'b0;
        end else if (accept) begin
            if (!forward) begin
                sof_miss <= 1'b1;
            end else if (in_eol) begin
                word_cnt <= '0;
                line_cnt <= last_line ? '0 : cur_line + 1'b1;
                state    <= last_line ? IDLE : ACTIVE;
            end else begin
                word_cnt <= (cur_word == LAST_WORD) ? '0 : cur_word + 1'b1;
                line_cnt <= cur_line;
                state    <= ACTIVE;
            end
        end
    end

`ifdef AXIS_FRAME_TX_LEN_CHECK_EN
    logic len_err_q;

    // Flags an eol arriving early, or a line running past its last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_err_q <= 1'b0;
        end else if (forward && (in_eol != (cur_word == LAST_WORD))) begin
            len_err_q <= 1'b1;
        end
    end

    assign line_len_err = len_err_q;
`else
    assign line_len_err = 1'b0;
`endif

    axis_skid #(
        .WIDTH ($bits(tx_beat_t))
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_valid (forward),
        .s_ready (in_ready),
        .s_data  (push_beat),
        .m_valid (m_tvalid),
        .m_ready (m_tready),
        .m_data  (out_beat)
    );

    assign m_tdata    = out_beat.data;
    assign m_tuser    = out_beat.user;
    assign m_tlast    = out_beat.last;
    assign frame_done = m_tvalid && m_tready && out_beat.eof;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx with 4-word lines and 2-line frames; the
// expected line_len_err follows AXIS_FRAME_TX_LEN_CHECK_EN.
module tb_axis_frame_tx;
    import axis_pkg::*;

    localparam int DATA_W      = 32;
    localparam int LINE_WORDS  = 4;
    localparam int FRAME_LINES = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sof = 1'b0;
    logic              in_eol = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tuser;
    logic              m_tlast;
    logic              frame_done;
    logic              line_len_err;
    logic              sof_miss;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         drv_done = 1'b0;
    axis_beat_t exp_q[$];
    axis_beat_t obs_q[$];
    int         obs_cyc[$];
    int         acc_cyc[$];
    int         done_cyc[$];

    axis_frame_tx #(
        .DATA_W      (DATA_W),
        .LINE_WORDS  (LINE_WORDS),
        .FRAME_LINES (FRAME_LINES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_eol       (in_eol),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tuser      (m_tuser),
        .m_tlast      (m_tlast),
        .frame_done   (frame_done),
        .line_len_err (line_len_err),
        .sof_miss     (sof_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are logged mid-cycle; an entry stamped N completes at posedge N+1.
    always @(negedge clk) begin
        if (reset && in_valid && in_ready) acc_cyc.push_back(cyc);
        if (m_tvalid && m_tready) begin
            obs_q.push_back('{data: m_tdata, user: m_tuser, last: m_tlast});
            obs_cyc.push_back(cyc);
        end
        if (frame_done) done_cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        acc_cyc.delete();
        done_cyc.delete();
    endtask

    // Presents one beat and holds it until accepted; returns 1 unit after the accepting edge.
    task automatic drive_beat(input logic [DATA_W-1:0] d, input logic sof, input logic eol);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_eol   = eol;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout data %h not accepted within 50 cycles", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic send_frame(input bit rnd, input logic [DATA_W-1:0] base);
        for (int i = 0; i < LINE_WORDS * FRAME_LINES; i++) begin
            logic [DATA_W-1:0] d;
            logic              sof;
            logic              eol;
            d   = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
            sof = (i == 0);
            eol = ((i % LINE_WORDS) == LINE_WORDS - 1);
            exp_q.push_back('{data: d, user: sof, last: eol});
            drive_beat(d, sof, eol);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        step(2);
        checks++;
        if ({in_ready, m_tvalid, m_tuser, m_tlast, frame_done, line_len_err, sof_miss} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {in_ready, m_tvalid, m_tuser, m_tlast, frame_done, line_len_err, sof_miss});
        end
        checks++;
        if (m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata got %h want 0", m_tdata);
        end
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release got %b want 0", in_ready);
        end
        step(1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        m_tready = 1'b1;
        clear_logs();
        send_frame(1'b0, 32'hA000_0000);
        step(4);
        checks++;
        if (obs_q.size() !== 8) begin
            errors++;
            $display("FAIL basic_count got %0d want 8", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_cyc.size() == 8 && acc_cyc.size() == 8) begin
            checks++;
            if (obs_cyc[0] - acc_cyc[0] !== 1) begin
                errors++;
                $display("FAIL basic_latency got %0d want 1", obs_cyc[0] - acc_cyc[0]);
            end
            checks++;
            if (acc_cyc[7] - acc_cyc[0] !== 7) begin
                errors++;
                $display("FAIL basic_throughput got %0d cycles want 7", acc_cyc[7] - acc_cyc[0]);
            end
            checks++;
            if (done_cyc.size() !== 1 || done_cyc[0] !== acc_cyc[7] + 1) begin
                errors++;
                $display("FAIL basic_frame_done got %0d pulses (first at %0d) want 1 at %0d",
                         done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, acc_cyc[7] + 1);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL basic_log got %0d/%0d entries want 8/8", obs_cyc.size(), acc_cyc.size());
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = 32'hB000_0000 + DATA_W'(i);
        clear_logs();
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back('{data: b[i], user: (i == 0), last: (i == 3 || i == 7)});
        drive_beat(b[0], 1'b1, 1'b0);
        drive_beat(b[1], 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = b[2];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cycle %0d got %b want 0", k, in_ready);
            end
            checks++;
            if ({m_tvalid, m_tdata} !== {1'b1, b[0]}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got valid %b data %h want 1 %h", k, m_tvalid, m_tdata, b[0]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL stall_no_transfer got %0d want 0", obs_q.size());
        end
        m_tready = 1'b1;
        for (int i = 2; i < 8; i++) drive_beat(b[i], 1'b0, (i == 3 || i == 7));
        step(5);
        checks++;
        if (obs_q.size() !== 8 || done_cyc.size() !== 1) begin
            errors++;
            $display("FAIL stall_count got %0d beats %0d done want 8 1", obs_q.size(), done_cyc.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sof_miss();
        clear_logs();
        m_tready = 1'b1;
        checks++;
        if (sof_miss !== 1'b0) begin
            errors++;
            $display("FAIL sof_miss_before got %b want 0", sof_miss);
        end
        drive_beat(32'hC000_0000, 1'b0, 1'b0);
        drive_beat(32'hC000_0001, 1'b0, 1'b0);
        drive_beat(32'hC000_0002, 1'b0, 1'b1);
        step(3);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL sof_miss_dropped got %0d beats want 0", obs_q.size());
        end
        checks++;
        if (sof_miss !== 1'b1) begin
            errors++;
            $display("FAIL sof_miss_flag got %b want 1", sof_miss);
        end
        send_frame(1'b0, 32'hC100_0000);
        step(4);
        checks++;
        if (obs_q.size() !== 8 || done_cyc.size() !== 1) begin
            errors++;
            $display("FAIL sof_miss_frame_count got %0d beats %0d done want 8 1", obs_q.size(), done_cyc.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sof_miss_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_len_check();
        logic exp_err;
`ifdef AXIS_FRAME_TX_LEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_logs();
        m_tready = 1'b1;
        exp_q.push_back('{data: 32'hE000_0000, user: 1'b1, last: 1'b0});
        exp_q.push_back('{data: 32'hE000_0001, user: 1'b0, last: 1'b0});
        exp_q.push_back('{data: 32'hE000_0002, user: 1'b0, last: 1'b1});
        for (int i = 3; i < 7; i++) exp_q.push_back('{data: 32'hE000_0000 + DATA_W'(i), user: 1'b0, last: (i == 6)});
        drive_beat(32'hE000_0000, 1'b1, 1'b0);
        drive_beat(32'hE000_0001, 1'b0, 1'b0);
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_err_early got %b want 0", line_len_err);
        end
        drive_beat(32'hE000_0002, 1'b0, 1'b1);
        checks++;
        if (line_len_err !== exp_err) begin
            errors++;
            $display("FAIL len_err_short_line got %b want %b", line_len_err, exp_err);
        end
        for (int i = 3; i < 7; i++) drive_beat(32'hE000_0000 + DATA_W'(i), 1'b0, (i == 6));
        step(4);
        checks++;
        if (obs_q.size() !== 7 || done_cyc.size() !== 1) begin
            errors++;
            $display("FAIL len_count got %0d beats %0d done want 7 1", obs_q.size(), done_cyc.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL len_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        m_tready = 1'b0;
        drive_beat(32'hF000_0000, 1'b1, 1'b0);
        drive_beat(32'hF000_0001, 1'b0, 1'b0);
        checks++;
        if ({m_tvalid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_buffered got valid %b ready %b want 1 0", m_tvalid, in_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, m_tvalid, m_tuser, m_tlast, frame_done, line_len_err, sof_miss} !== 7'b0
            || m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got flags %b data %h want 0",
                     {in_ready, m_tvalid, m_tuser, m_tlast, frame_done, line_len_err, sof_miss}, m_tdata);
        end
        step(2);
        reset = 1'b1;
        m_tready = 1'b1;
        step(2);
        send_frame(1'b0, 32'hD000_0000);
        step(4);
        checks++;
        if (obs_q.size() !== 8 || done_cyc.size() !== 1) begin
            errors++;
            $display("FAIL reset_mid_count got %0d beats %0d done want 8 1", obs_q.size(), done_cyc.size());
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[0].user !== 1'b1 || obs_q[0].data !== 32'hD000_0000) begin
            errors++;
            $display("FAIL reset_mid_first got %h want data d0000000 user 1",
                     (obs_q.size() > 0) ? obs_q[0] : '0);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        drv_done = 1'b0;
        fork
            begin
                send_frame(1'b1, '0);
                send_frame(1'b1, '0);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    m_tready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        m_tready = 1'b1;
        step(8);
        checks++;
        if (obs_q.size() !== exp_q.size() || done_cyc.size() !== 2) begin
            errors++;
            $display("FAIL random_count got %0d beats %0d done want %0d 2",
                     obs_q.size(), done_cyc.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_sof_miss();
        test_len_check();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
